// File: rtl/updown_button_ctrl.sv
// Push-button front end for the 8-bit up/down counter: synchronise and debounce
// both buttons, then emit single-cycle inc/dec commands with hold-to-repeat.
module updown_button_ctrl #(
  parameter int DEB_CYCLES  = 250000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int RPT_CYCLES  = 5000000,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       enable,
  output logic [1:0] control,
  output logic       up_level,
  output logic       down_level
);

  localparam int NUM_BTN = 2;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  // Index 0 is the up button, index 1 the down button.
  logic [NUM_BTN-1:0]            btn_raw;
  logic [NUM_BTN-1:0][1:0]       sync_q, sync_d;
  logic [NUM_BTN-1:0]            lvl_q, lvl_d;
  logic [NUM_BTN-1:0]            lvl_prev_q, lvl_prev_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_BTN-1:0]            rise;

  state_t           state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       control_q, control_d;

  logic up, dn, active, other;

  assign btn_raw = {btn_down, btn_up};

  // Debounce: a level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      sync_d[i]    = {sync_q[i][0], btn_raw[i]};
      lvl_d[i]     = lvl_q[i];
      deb_cnt_d[i] = '0;
      if (sync_q[i][1] != lvl_q[i]) begin
        if (deb_cnt_q[i] >= DEB_LAST) lvl_d[i] = ~lvl_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
      end
    end
    lvl_prev_d = lvl_q;
  end

  assign rise   = lvl_q & ~lvl_prev_q;
  assign up     = lvl_q[0];
  assign dn     = lvl_q[1];
  assign active = dir_up_q ? up : dn;
  assign other  = dir_up_q ? dn : up;

  always_comb begin
    state_d   = state_q;
    dir_up_d  = dir_up_q;
    timer_d   = timer_q;
    control_d = CMD_NONE;
    if (!enable) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (up && dn) begin
            state_d = LOCK;
          end else if (rise[0] && !dn) begin
            control_d = CMD_INC;
            dir_up_d  = 1'b1;
            timer_d   = '0;
            state_d   = DELAY;
          end else if (rise[1] && !up) begin
            control_d = CMD_DEC;
            dir_up_d  = 1'b0;
            timer_d   = '0;
            state_d   = DELAY;
          end
        end
        DELAY, REPEAT: begin
          // Collision beats release, release beats timer expiry.
          if (other) begin
            state_d = LOCK;
            timer_d = '0;
          end else if (!active) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q >= ((state_q == DELAY) ? HOLD_LAST : RPT_LAST)) begin
            control_d = dir_up_q ? CMD_INC : CMD_DEC;
            timer_d   = '0;
            state_d   = REPEAT;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        LOCK: begin
          if (!up && !dn) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      dir_up_q   <= 1'b0;
      timer_q    <= '0;
      control_q  <= CMD_NONE;
    end else begin
      sync_q     <= sync_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      dir_up_q   <= dir_up_d;
      timer_q    <= timer_d;
      control_q  <= control_d;
    end
  end

  assign control    = control_q;
  assign up_level   = lvl_q[0];
  assign down_level = lvl_q[1];

endmodule

// File: tb/tb_updown_button_ctrl.sv
// Directed bench for updown_button_ctrl: an event-level reference model checked
// every cycle, plus hand-computed pulse timings per scenario.
module tb_updown_button_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int RPT  = 3;
  localparam int CW   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] control;
  logic       up_level, down_level;

  updown_button_ctrl #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .enable(enable), .control(control), .up_level(up_level), .down_level(down_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  bit mon_on = 1'b0;
  int pl_cyc[$];
  int pl_code[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - t0);
    end
  endtask

  // Reference model: levels from raw-sample history, commands from event times.
  localparam int M_IDLE = 0, M_HELD = 1, M_LOCK = 2;
  bit hu[$], hd[$];
  bit m_up = 0, m_dn = 0, pu = 0, pd = 0, m_dir_up = 0;
  logic [1:0] m_ctrl = 2'b00;
  int mode = M_IDLE;
  int next_fire = 0;

  always @(negedge clk) begin
    bit du, dd, nu, nd, act_l, oth_l;
    logic [1:0] cmd;
    if (mon_on) begin
      chk("control", {30'd0, control}, {30'd0, m_ctrl});
      chk("up_level", {31'd0, up_level}, {31'd0, m_up});
      chk("down_level", {31'd0, down_level}, {31'd0, m_dn});
      if (control != 2'b00) begin
        pl_cyc.push_back(cyc);
        pl_code.push_back(int'(control));
      end
    end
    if (reset) begin
      hu.delete(); hd.delete();
      for (int k = 0; k <= DEB; k++) begin hu.push_back(1'b0); hd.push_back(1'b0); end
      m_up = 0; m_dn = 0; pu = 0; pd = 0; m_ctrl = 2'b00; mode = M_IDLE;
    end else begin
      // hu[k] = raw sampled k+1 cycles ago; the synchronised value now is hu[1].
      du = 1; dd = 1;
      for (int k = 1; k <= DEB; k++) begin
        if (hu[k] == m_up) du = 0;
        if (hd[k] == m_dn) dd = 0;
      end
      nu = du ? !m_up : m_up;
      nd = dd ? !m_dn : m_dn;
      cmd = 2'b00;
      if (!enable) begin
        mode = M_IDLE;
      end else if (mode == M_IDLE) begin
        if (m_up && m_dn) mode = M_LOCK;
        else if (m_up && !pu && !m_dn) begin
          cmd = 2'b01; m_dir_up = 1; next_fire = cyc + HOLD; mode = M_HELD;
        end else if (m_dn && !pd && !m_up) begin
          cmd = 2'b10; m_dir_up = 0; next_fire = cyc + HOLD; mode = M_HELD;
        end
      end else if (mode == M_HELD) begin
        act_l = m_dir_up ? m_up : m_dn;
        oth_l = m_dir_up ? m_dn : m_up;
        if (oth_l) mode = M_LOCK;
        else if (!act_l) mode = M_IDLE;
        else if (cyc == next_fire) begin
          cmd = m_dir_up ? 2'b01 : 2'b10;
          next_fire = cyc + RPT;
        end
      end else begin
        if (!m_up && !m_dn) mode = M_IDLE;
      end
      pu = m_up; pd = m_dn; m_up = nu; m_dn = nd; m_ctrl = cmd;
      hu.push_front(btn_up); void'(hu.pop_back());
      hd.push_front(btn_down); void'(hd.pop_back());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    t0 = cyc;
    pl_cyc.delete();
    pl_code.delete();
  endtask

  task automatic settle();
    btn_up = 0; btn_down = 0; enable = 1; reset = 0;
    repeat (20) step();
  endtask

  task automatic check_pulses(input string nm, input int exp_c[$], input int code);
    chk({nm, "_count"}, pl_cyc.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < pl_cyc.size(); i++) begin
      chk({nm, "_cycle"}, pl_cyc[i] - t0, exp_c[i]);
      chk({nm, "_code"}, pl_code[i], code);
    end
  endtask

  initial begin
    int e[$];
    // 1: reset with both buttons high
    btn_up = 1; btn_down = 1;
    step(); mon_on = 1; step();
    chk("t1_ctrl_rst", {30'd0, control}, 32'd0);
    chk("t1_up_rst", {31'd0, up_level}, 32'd0);
    chk("t1_dn_rst", {31'd0, down_level}, 32'd0);
    reset = 0;
    start_test();
    repeat (6) step();
    e.delete(); check_pulses("t1", e, 0);
    settle();

    // 2: clean press of 8 cycles
    start_test();
    for (int k = 0; k < 30; k++) begin
      btn_up = (k < 8);
      if (k == 5)  chk("t2_up_pre", {31'd0, up_level}, 32'd0);
      if (k == 6)  chk("t2_up_rise", {31'd0, up_level}, 32'd1);
      if (k == 13) chk("t2_up_hold", {31'd0, up_level}, 32'd1);
      if (k == 14) chk("t2_up_fall", {31'd0, up_level}, 32'd0);
      step();
    end
    e = '{7}; check_pulses("t2", e, 1);
    settle();

    // 3: bouncing input then steady
    start_test();
    for (int k = 0; k < 40; k++) begin
      btn_up = (k < 12) ? ((k % 4) < 2) : (k < 22);
      step();
    end
    e = '{19}; check_pulses("t3", e, 1);
    settle();

    // 4: long hold of btn_down
    start_test();
    for (int k = 0; k < 60; k++) begin
      btn_down = (k < 40);
      step();
    end
    e = '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44}; check_pulses("t4", e, 2);
    settle();

    // 5a: both buttons together
    start_test();
    for (int k = 0; k < 30; k++) begin
      btn_up = (k < 8); btn_down = (k < 8);
      step();
    end
    e.delete(); check_pulses("t5a", e, 0);
    settle();

    // 5b: collision during hold, then re-press required
    start_test();
    for (int k = 0; k < 70; k++) begin
      btn_up   = (k < 30) || (k >= 40 && k < 50);
      btn_down = (k >= 8 && k < 20);
      step();
    end
    e = '{7, 47}; check_pulses("t5b", e, 1);
    settle();

    // 6a: enable dropped mid-repeat, restored while held
    start_test();
    for (int k = 0; k < 40; k++) begin
      btn_up = (k < 34);
      enable = !(k >= 22 && k < 26);
      if (k == 23) chk("t6a_ctrl_dis", {30'd0, control}, 32'd0);
      step();
    end
    e = '{7, 17, 20}; check_pulses("t6a", e, 1);
    settle();

    // 6b: reset mid-repeat while held
    start_test();
    for (int k = 0; k < 45; k++) begin
      btn_down = (k < 35);
      reset = (k == 22);
      if (k == 23) begin
        chk("t6b_ctrl_rst", {30'd0, control}, 32'd0);
        chk("t6b_dn_rst", {31'd0, down_level}, 32'd0);
        chk("t6b_up_rst", {31'd0, up_level}, 32'd0);
      end
      step();
    end
    e = '{7, 17, 20, 30, 40}; check_pulses("t6b", e, 2);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
